// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit frame engine.
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    typedef struct packed {
        logic par_en;
        logic par_typ;
        logic stop2;
    } frame_cfg_t;
endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// uart_tx_frame_engine_if: word handshake, frame options, tick and serial line of the UART TX engine.
interface uart_tx_frame_engine_if #(parameter int DATA_WIDTH = 8);
    logic                  tx_tick;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  tx_ready;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  tx_out;
    logic                  busy;
    modport master (output tx_tick, p_data, data_valid, par_en, par_typ, stop2,
                    input  tx_ready, tx_out, busy);
    modport slave  (input  tx_tick, p_data, data_valid, par_en, par_typ, stop2,
                    output tx_ready, tx_out, busy);
endinterface

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational even/odd parity of a DATA_WIDTH-bit word.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_o
);
    assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: serialises start, data (LSB first), optional parity and 1/2 stop bits on TX_TICK.
// Define UART_TX_HOLD_BUF_EN to accept the next word mid-frame for gapless back-to-back frames.
module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    uart_tx_frame_engine_if.slave bus_io
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, pend_data_q, pend_data_d;
    frame_cfg_t            cfg_q, cfg_d, pend_cfg_q, pend_cfg_d;
    logic                  par_q, par_d, tx_q, tx_d, pend_q, pend_d;
    logic                  pend_par, take, load;

    uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data_i    (pend_data_q),
        .par_typ_i (pend_cfg_q.par_typ),
        .par_o     (pend_par)
    );

`ifdef UART_TX_HOLD_BUF_EN
    assign bus_io.tx_ready = !pend_q;
`else
    assign bus_io.tx_ready = (state_q == IDLE) && !pend_q;
`endif
    assign bus_io.busy   = (state_q != IDLE) || pend_q;
    assign bus_io.tx_out = tx_q;
    assign take          = bus_io.data_valid && bus_io.tx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        cfg_d   = cfg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
        if (bus_io.tx_tick) begin
            case (state_q)
                IDLE:   load = pend_q;
                START: begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = cfg_q.par_en ? PARITY : STOP;
                        tx_d    = cfg_q.par_en ? par_q : 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (cnt_q == CNT_W'(cfg_q.stop2)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        load    = pend_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A pending word always starts its frame on the tick that frees the shifter
            if (load) begin
                state_d = START;
                shreg_d = pend_data_q;
                cfg_d   = pend_cfg_q;
                par_d   = pend_par;
                tx_d    = 1'b0;
            end
        end
        pend_d      = take ? 1'b1 : (load ? 1'b0 : pend_q);
        pend_data_d = take ? bus_io.p_data : pend_data_q;
        pend_cfg_d  = take ? frame_cfg_t'{par_en: bus_io.par_en, par_typ: bus_io.par_typ, stop2: bus_io.stop2}
                           : pend_cfg_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            cfg_q       <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_cfg_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            cfg_q       <= cfg_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_cfg_q  <= pend_cfg_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: table-driven, directed and randomized checks of the UART TX frame engine.
module tb_uart_tx_frame_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tick_per = 1;
    int   tcnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    uart_tx_frame_engine_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_frame_engine_if #(.DATA_WIDTH(5)) bus5 ();

    uart_tx_frame_engine #(.DATA_WIDTH(8), .CNT_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
    uart_tx_frame_engine #(.DATA_WIDTH(5), .CNT_W(3)) dut5 (.clk_i(clk), .rst_i(rst), .bus_io(bus5));

    always #5 clk = ~clk;

    initial begin
        bus.tx_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
            bus.tx_tick = (tcnt == 0);
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        pe, pt, s2;
        int          per;
        int          len;
        logic [15:0] bits;
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Frame as a list of line levels built from the framing rules
    function automatic void model(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                                  output logic [15:0] v, output int n);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back((^d) ^ pt);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        v = '0;
        foreach (q[i]) v[i] = q[i];
        n = q.size();
    endfunction

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        bit acc = 0;
        bus.p_data = d; bus.par_en = pe; bus.par_typ = pt; bus.stop2 = s2; bus.data_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                @(posedge clk);
                acc = 1;
            end
        end
        #1;
        bus.data_valid = 1'b0; bus.p_data = ~d; bus.par_en = ~pe; bus.par_typ = ~pt; bus.stop2 = ~s2;
        chk($sformatf("accept %0h", d), acc, 1);
    endtask

    task automatic wait_start(input int per, output bit got, output int waited);
        got = 0;
        waited = 0;
        for (int i = 0; i < per + 6 && !got; i++) begin
            @(negedge clk);
            waited++;
            got = (bus.tx_out == 1'b0);
        end
        chk("start_seen", got, 1);
    endtask

    task automatic check_frame(input logic [15:0] exp, input int len, input int per, input string nm,
                               output int waited);
        bit   got;
        logic act;
        wait_start(per, got, waited);
        if (got) begin
            chk({nm, " busy"}, bus.busy, 1);
            for (int k = 0; k < len; k++) begin
                act = exp[k];
                for (int j = 0; j < per; j++) begin
                    if (k != 0 || j != 0) @(negedge clk);
                    if (bus.tx_out !== exp[k]) act = bus.tx_out;
                end
                chk($sformatf("%s bit%0d", nm, k), act, exp[k]);
            end
        end
    endtask

    task automatic idle_chk(input int per, input string nm);
        repeat (per + 1) @(negedge clk);
        chk({nm, " idle tx"}, bus.tx_out, 1);
        chk({nm, " idle busy"}, bus.busy, 0);
        chk({nm, " idle ready"}, bus.tx_ready, 1);
    endtask

    initial begin
        int          w;
        bit          got;
        logic [15:0] v;
        int          n;
        logic        act;
        int          pers[4] = '{1, 2, 4, 7};
        logic [7:0]  exp5;
        tv[0] = '{"a5_basic",  8'hA5, 1'b0, 1'b0, 1'b0, 1,  10, 16'h034A};
        tv[1] = '{"07_even",   8'h07, 1'b1, 1'b0, 1'b0, 1,  11, 16'h060E};
        tv[2] = '{"07_odd",    8'h07, 1'b1, 1'b1, 1'b0, 1,  11, 16'h040E};
        tv[3] = '{"07_stop2",  8'h07, 1'b1, 1'b0, 1'b1, 1,  12, 16'h0E0E};
        tv[4] = '{"a5_tick16", 8'hA5, 1'b0, 1'b0, 1'b0, 16, 10, 16'h034A};
        bus.p_data = '0; bus.data_valid = 0; bus.par_en = 0; bus.par_typ = 0; bus.stop2 = 0;
        bus5.tx_tick = 1; bus5.p_data = '0; bus5.data_valid = 0; bus5.par_en = 0; bus5.par_typ = 0; bus5.stop2 = 0;
        repeat (3) @(negedge clk);
        chk("reset tx_out", bus.tx_out, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset ready", bus.tx_ready, 1);
        chk("reset5 tx_out", bus5.tx_out, 1);
        rst = 1'b0;

        foreach (tv[i]) begin
            tick_per = tv[i].per;
            send(tv[i].data, tv[i].pe, tv[i].pt, tv[i].s2);
            check_frame(tv[i].bits, tv[i].len, tv[i].per, tv[i].name, w);
            idle_chk(tv[i].per, tv[i].name);
        end

        tick_per = 1;
        repeat (20) @(negedge clk);
        send(8'h55, 0, 0, 0);
        fork
            check_frame(16'h02AA, 10, 1, "b2b_55", w);
            begin
                repeat (3) @(negedge clk);
`ifdef UART_TX_HOLD_BUF_EN
                chk("b2b ready mid", bus.tx_ready, 1);
                send(8'hAA, 0, 0, 0);
                chk("b2b ready full", bus.tx_ready, 0);
`else
                chk("b2b ready mid", bus.tx_ready, 0);
                send(8'hAA, 0, 0, 0);
`endif
            end
        join
        check_frame(16'h0354, 10, 1, "b2b_aa", w);
`ifdef UART_TX_HOLD_BUF_EN
        chk("b2b gapless", w, 1);
`else
        chk("b2b idle gap", w >= 2, 1);
`endif
        idle_chk(1, "b2b");

        send(8'hA5, 0, 0, 0);
        wait_start(1, got, w);
        repeat (5) @(negedge clk);
        chk("rst bit4", bus.tx_out, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst tx_out", bus.tx_out, 1);
        chk("rst busy", bus.busy, 0);
        chk("rst ready", bus.tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        send(8'h3C, 1, 1, 1);
        model(8'h3C, 1, 1, 1, v, n);
        check_frame(v, n, 1, "post_rst", w);
        idle_chk(1, "post_rst");

        for (int r = 0; r < 16; r++) begin
            logic [7:0] d = 8'($urandom);
            logic pe = 1'($urandom), pt = 1'($urandom), s2 = 1'($urandom);
            tick_per = pers[$urandom_range(0, 3)];
            model(d, pe, pt, s2, v, n);
            send(d, pe, pt, s2);
            check_frame(v, n, tick_per, $sformatf("rnd%0d_%0h", r, d), w);
            idle_chk(tick_per, "rnd");
        end

        exp5 = 8'hBE;
        got = 0;
        @(negedge clk);
        bus5.p_data = 5'h1F; bus5.par_en = 1; bus5.par_typ = 1; bus5.stop2 = 0; bus5.data_valid = 1;
        @(posedge clk);
        #1 bus5.data_valid = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            got = (bus5.tx_out == 1'b0);
        end
        chk("dw5 start_seen", got, 1);
        if (got) begin
            for (int k = 0; k < 8; k++) begin
                if (k != 0) @(negedge clk);
                if (k == 2) bus5.par_en = 0;
                act = bus5.tx_out;
                chk($sformatf("dw5 bit%0d", k), act, exp5[k]);
            end
        end
        repeat (2) @(negedge clk);
        chk("dw5 idle tx", bus5.tx_out, 1);
        chk("dw5 idle busy", bus5.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
